// File: rtl/lis3dh_pkg.sv
// Shared constants and types for the LIS3DH bring-up and polling sequencer.
package lis3dh_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned NBITS_W = 6;
  localparam int unsigned AXIS_W  = 16;
  localparam int unsigned CNT_W   = 32;

  localparam logic [5:0] ADDR_WHO_AM_I  = 6'h0F;
  localparam logic [5:0] ADDR_CTRL_REG1 = 6'h20;
  localparam logic [5:0] ADDR_CTRL_REG4 = 6'h23;
  localparam logic [5:0] ADDR_OUT_X_L   = 6'h28;
  localparam logic [5:0] ADDR_OUT_Y_L   = 6'h2A;
  localparam logic [5:0] ADDR_OUT_Z_L   = 6'h2C;

  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned CMD_MS_BIT = 6;

  localparam logic [NBITS_W-1:0] NBITS_16 = 6'd15;
  localparam logic [NBITS_W-1:0] NBITS_24 = 6'd23;

  typedef enum logic [2:0] {
    STEP_WHO   = 3'd0,
    STEP_CTRL1 = 3'd1,
    STEP_CTRL4 = 3'd2,
    STEP_X     = 3'd3,
    STEP_Y     = 3'd4,
    STEP_Z     = 3'd5
  } step_e;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_ISSUE     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_DECODE    = 3'd4;
  localparam logic [2:0] ST_PERIOD    = 3'd5;
  localparam logic [2:0] ST_ERROR     = 3'd6;

  typedef struct packed {
    logic [DATA_W-1:0]  mosi_data;
    logic [NBITS_W-1:0] nbits;
  } spi_xfer_t;

  // Command byte: bit 7 = read, bit 6 = address auto-increment.
  function automatic logic [7:0] mk_cmd(input logic rd, input logic inc, input logic [5:0] addr);
    logic [7:0] cmd;
    cmd             = {2'b00, addr};
    cmd[CMD_RW_BIT] = rd;
    cmd[CMD_MS_BIT] = inc;
    return cmd;
  endfunction

endpackage

// File: rtl/lis3dh_poll_ctrl_if.sv
// Request/ready handshake bundle between the sequencer and spi_master.
interface lis3dh_poll_ctrl_if;
  import lis3dh_pkg::*;

  logic                spi_request;
  logic [DATA_W-1:0]   spi_mosi_data;
  logic [NBITS_W-1:0]  spi_nbits;
  logic [DATA_W-1:0]   spi_miso_data;
  logic                spi_ready;

  modport master (
    output spi_request, spi_mosi_data, spi_nbits,
    input  spi_miso_data, spi_ready
  );

  modport slave (
    input  spi_request, spi_mosi_data, spi_nbits,
    output spi_miso_data, spi_ready
  );
endinterface

// File: rtl/lis3dh_step_rom.sv
// Maps a sequencer step to the SPI frame (mosi word and N-1 bit count) it sends.
module lis3dh_step_rom
  import lis3dh_pkg::*;
#(
  parameter logic [7:0] CTRL1_VAL = 8'h77,
  parameter logic [7:0] CTRL4_VAL = 8'h88
) (
  input  step_e     step,
  output spi_xfer_t xfer_c
);

  always_comb begin
    xfer_c = '0;
    case (step)
      STEP_WHO: begin
        xfer_c.mosi_data = {16'h0000, mk_cmd(1'b1, 1'b0, ADDR_WHO_AM_I), 8'h00};
        xfer_c.nbits     = NBITS_16;
      end
      STEP_CTRL1: begin
        xfer_c.mosi_data = {16'h0000, mk_cmd(1'b0, 1'b0, ADDR_CTRL_REG1), CTRL1_VAL};
        xfer_c.nbits     = NBITS_16;
      end
      STEP_CTRL4: begin
        xfer_c.mosi_data = {16'h0000, mk_cmd(1'b0, 1'b0, ADDR_CTRL_REG4), CTRL4_VAL};
        xfer_c.nbits     = NBITS_16;
      end
      STEP_X: begin
        xfer_c.mosi_data = {8'h00, mk_cmd(1'b1, 1'b1, ADDR_OUT_X_L), 16'h0000};
        xfer_c.nbits     = NBITS_24;
      end
      STEP_Y: begin
        xfer_c.mosi_data = {8'h00, mk_cmd(1'b1, 1'b1, ADDR_OUT_Y_L), 16'h0000};
        xfer_c.nbits     = NBITS_24;
      end
      STEP_Z: begin
        xfer_c.mosi_data = {8'h00, mk_cmd(1'b1, 1'b1, ADDR_OUT_Z_L), 16'h0000};
        xfer_c.nbits     = NBITS_24;
      end
      default: xfer_c = '0;
    endcase
  end

endmodule

// File: rtl/lis3dh_poll_ctrl.sv
// LIS3DH sequencer: WHO_AM_I check, CTRL_REG1/4 setup, then periodic X/Y/Z reads via spi_master.
module lis3dh_poll_ctrl
  import lis3dh_pkg::*;
#(
  parameter logic [31:0] POLL_DIV   = 32'd1_000_000,
  parameter logic [31:0] TIMEOUT    = 32'd2_000_000,
  parameter logic [7:0]  CTRL1_VAL  = 8'h77,
  parameter logic [7:0]  CTRL4_VAL  = 8'h88,
  parameter logic [7:0]  WHOAMI_VAL = 8'h33
) (
  input  logic                     clk_in,
  input  logic                     nrst,
  input  logic                     enable,
  lis3dh_poll_ctrl_if.master       spi,
  output logic                     running,
  output logic                     id_error,
  output logic                     sample_valid,
  output logic signed [AXIS_W-1:0] acc_x,
  output logic signed [AXIS_W-1:0] acc_y,
  output logic signed [AXIS_W-1:0] acc_z
);

  logic [2:0]               state_q, state_d;
  step_e                    step_q, step_d;
  logic [CNT_W-1:0]         tmo_q, tmo_d;
  logic [CNT_W-1:0]         poll_q, poll_d;
  logic signed [AXIS_W-1:0] shadow_x_q, shadow_x_d;
  logic signed [AXIS_W-1:0] shadow_y_q, shadow_y_d;
  logic signed [AXIS_W-1:0] acc_x_d, acc_y_d, acc_z_d;
  logic                     id_error_d;
  logic                     sample_valid_d;
  logic                     running_d;
  spi_xfer_t                xfer_c;
  logic signed [AXIS_W-1:0] axis_c;
  logic                     unused_miso_hi;

  lis3dh_step_rom #(
    .CTRL1_VAL (CTRL1_VAL),
    .CTRL4_VAL (CTRL4_VAL)
  ) u_step_rom (
    .step   (step_d),
    .xfer_c (xfer_c)
  );

  // Sensor returns the low byte first, so it lands in the upper miso byte.
  assign axis_c         = $signed({spi.spi_miso_data[7:0], spi.spi_miso_data[15:8]});
  assign unused_miso_hi = ^spi.spi_miso_data[31:16];

  // Next-state and next-output logic.
  always_comb begin
    state_d        = state_q;
    step_d         = step_q;
    tmo_d          = tmo_q;
    poll_d         = poll_q + 32'd1;
    shadow_x_d     = shadow_x_q;
    shadow_y_d     = shadow_y_q;
    acc_x_d        = acc_x;
    acc_y_d        = acc_y;
    acc_z_d        = acc_z;
    id_error_d     = id_error;
    sample_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        tmo_d  = '0;
        poll_d = '0;
        if (enable) begin
          step_d  = STEP_WHO;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        tmo_d = 32'd1;
        if (step_q == STEP_X) begin
          poll_d = 32'd1;
        end
        state_d = ST_WAIT_ACK;
      end

      ST_WAIT_ACK: begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_q == TIMEOUT - 32'd1) begin
          id_error_d = 1'b1;
          state_d    = ST_ERROR;
        end else if (!spi.spi_ready) begin
          state_d = ST_WAIT_DONE;
        end
      end

      ST_WAIT_DONE: begin
        tmo_d = tmo_q + 32'd1;
        if (tmo_q == TIMEOUT - 32'd1) begin
          id_error_d = 1'b1;
          state_d    = ST_ERROR;
        end else if (spi.spi_ready) begin
          state_d = ST_DECODE;
        end
      end

      // A transfer that finished after enable dropped is discarded here.
      ST_DECODE: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ISSUE;
          case (step_q)
            STEP_WHO: begin
              if (spi.spi_miso_data[7:0] != WHOAMI_VAL) begin
                id_error_d = 1'b1;
                state_d    = ST_ERROR;
              end else begin
                step_d = STEP_CTRL1;
              end
            end
            STEP_CTRL1: step_d = STEP_CTRL4;
            STEP_CTRL4: step_d = STEP_X;
            STEP_X: begin
              shadow_x_d = axis_c;
              step_d     = STEP_Y;
            end
            STEP_Y: begin
              shadow_y_d = axis_c;
              step_d     = STEP_Z;
            end
            STEP_Z: begin
              acc_x_d        = shadow_x_q;
              acc_y_d        = shadow_y_q;
              acc_z_d        = axis_c;
              sample_valid_d = 1'b1;
              step_d         = STEP_X;
              state_d        = ST_PERIOD;
            end
            default: state_d = ST_IDLE;
          endcase
        end
      end

      // A read that overran the period reissues at once without catching up.
      ST_PERIOD: begin
        if (!enable) begin
          state_d = ST_IDLE;
        end else if (poll_q >= POLL_DIV - 32'd1) begin
          step_d  = STEP_X;
          state_d = ST_ISSUE;
        end
      end

      ST_ERROR: begin
        poll_d = '0;
        if (!enable) begin
          id_error_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    running_d = (state_d != ST_IDLE) && (state_d != ST_ERROR) &&
                (step_d inside {STEP_X, STEP_Y, STEP_Z});
  end

  // State, timers, shadows and registered outputs.
  always_ff @(posedge clk_in) begin
    if (!nrst) begin
      state_q           <= ST_IDLE;
      step_q            <= STEP_WHO;
      tmo_q             <= '0;
      poll_q            <= '0;
      shadow_x_q        <= '0;
      shadow_y_q        <= '0;
      spi.spi_request   <= 1'b0;
      spi.spi_mosi_data <= '0;
      spi.spi_nbits     <= '0;
      running           <= 1'b0;
      id_error          <= 1'b0;
      sample_valid      <= 1'b0;
      acc_x             <= '0;
      acc_y             <= '0;
      acc_z             <= '0;
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      tmo_q           <= tmo_d;
      poll_q          <= poll_d;
      shadow_x_q      <= shadow_x_d;
      shadow_y_q      <= shadow_y_d;
      spi.spi_request <= (state_d == ST_ISSUE);
      if (state_d == ST_ISSUE) begin
        spi.spi_mosi_data <= xfer_c.mosi_data;
        spi.spi_nbits     <= xfer_c.nbits;
      end
      running      <= running_d;
      id_error     <= id_error_d;
      sample_valid <= sample_valid_d;
      acc_x        <= acc_x_d;
      acc_y        <= acc_y_d;
      acc_z        <= acc_z_d;
    end
  end

endmodule
